// File: rtl/gun_pos_accum_if.sv
// Control and position bundle for gun_pos_accum: frame tick, per-axis direction requests,
// mode/recenter controls and the resulting positions and status flags.
interface gun_pos_accum_if #(
  parameter int CHANNELS = 2,
  parameter int POS_W    = 8
);
  logic                      tick;
  logic [CHANNELS-1:0]       dir_inc;
  logic [CHANNELS-1:0]       dir_dec;
  logic                      wrap_mode;
  logic                      center;
  logic [CHANNELS*POS_W-1:0] pos;
  logic [CHANNELS-1:0]       moving;
  logic                      done;
  logic                      overrun;

  modport master (
    output tick, dir_inc, dir_dec, wrap_mode, center,
    input  pos, moving, done, overrun
  );

  modport slave (
    input  tick, dir_inc, dir_dec, wrap_mode, center,
    output pos, moving, done, overrun
  );
endinterface

// File: rtl/gun_pos_accum.sv
// Gun position accumulator: each frame tick starts a pass that updates one axis per cycle.
// Define GUN_ACCEL_EN for per-axis acceleration; otherwise every moving tick steps by STEP_MAX.
module gun_pos_accum #(
  parameter int CHANNELS    = 2,
  parameter int POS_W       = 8,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 255,
  parameter int POS_CENTER  = 128,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 8
) (
  input logic            clk_sys,
  input logic            reset_n,
  gun_pos_accum_if.slave bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SPD_W = $clog2(STEP_MAX + 1);
  localparam int SUM_W = POS_W + 2;
  localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [POS_W-1:0]        CENTER_V = POS_W'(POS_CENTER);
  localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(POS_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(POS_MAX);
  localparam logic signed [SUM_W-1:0] ONE_S    = SUM_W'(1);

  if (POS_MIN > POS_CENTER || POS_CENTER > POS_MAX || STEP_MAX < 1 ||
      STEP_MAX > POS_MAX - POS_MIN || ACCEL_TICKS < 1) begin : g_bad_cfg
    $error("gun_pos_accum: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic                pending_reg, pending_next;
  logic                overrun_reg, overrun_next;
  logic                start;
  logic [CHANNELS-1:0] snap_inc_reg, snap_dec_reg;
  logic                snap_wrap_reg;

  always_comb begin
    state_next   = state_reg;
    ch_next      = ch_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    start        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.tick) begin
          start      = 1'b1;
          state_next = UPDATE;
          ch_next    = '0;
        end
      end
      UPDATE: begin
        if (bus.tick) begin
          if (pending_reg) overrun_next = 1'b1;
          else             pending_next = 1'b1;
        end
        if (ch_reg == CH_LAST) state_next = DONE;
        else                   ch_next    = ch_reg + 1'b1;
      end
      DONE: begin
        // A queued tick restarts straight from here; a tick landing on top of it is lost.
        if (pending_reg || bus.tick) begin
          start        = 1'b1;
          pending_next = 1'b0;
          state_next   = UPDATE;
          ch_next      = '0;
          if (pending_reg && bus.tick) overrun_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.center) begin
      state_next   = IDLE;
      ch_next      = '0;
      pending_next = 1'b0;
      overrun_next = overrun_reg;
      start        = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      pending_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      snap_inc_reg  <= '0;
      snap_dec_reg  <= '0;
      snap_wrap_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      if (start) begin
        snap_inc_reg  <= bus.dir_inc;
        snap_dec_reg  <= bus.dir_dec;
        snap_wrap_reg <= bus.wrap_mode;
      end
    end
  end

  assign bus.done    = (state_reg == DONE);
  assign bus.overrun = overrun_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [POS_W-1:0]        pos_reg, pos_next;
    logic                    moving_reg;
    logic [SPD_W-1:0]        step;
    logic                    active, mv, up;
    logic signed [SUM_W-1:0] sum;

    assign active = (state_reg == UPDATE) && (ch_reg == CH_W'(gi));
    assign mv     = snap_inc_reg[gi] ^ snap_dec_reg[gi];
    assign up     = snap_inc_reg[gi];

`ifdef GUN_ACCEL_EN
    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
    logic [SPD_W-1:0] speed_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg;

    // cnt_reg counts ticks spent at the current speed; a full run bumps the speed.
    always_comb begin
      step     = SPD_W'(1);
      cnt_next = CNT_W'(1);
      if (speed_reg != '0 && dir_reg == up) begin
        if (cnt_reg == CNT_W'(ACCEL_TICKS)) begin
          step = (speed_reg < SPD_W'(STEP_MAX)) ? speed_reg + 1'b1 : speed_reg;
        end else begin
          step     = speed_reg;
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        speed_reg <= '0;
        cnt_reg   <= '0;
        dir_reg   <= 1'b0;
      end else if (bus.center) begin
        speed_reg <= '0;
        cnt_reg   <= '0;
      end else if (active) begin
        if (mv) begin
          speed_reg <= step;
          cnt_reg   <= cnt_next;
          dir_reg   <= up;
        end else begin
          speed_reg <= '0;
          cnt_reg   <= '0;
        end
      end
    end
`else
    assign step = SPD_W'(STEP_MAX);
`endif

    always_comb begin
      sum      = up ? SUM_W'(pos_reg) + SUM_W'(step) : SUM_W'(pos_reg) - SUM_W'(step);
      pos_next = POS_W'(sum);
      if (sum > MAX_S)
        pos_next = snap_wrap_reg ? POS_W'(MIN_S + sum - MAX_S - ONE_S) : POS_W'(MAX_S);
      else if (sum < MIN_S)
        pos_next = snap_wrap_reg ? POS_W'(MAX_S - (MIN_S - sum - ONE_S)) : POS_W'(MIN_S);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        pos_reg    <= CENTER_V;
        moving_reg <= 1'b0;
      end else if (bus.center) begin
        pos_reg    <= CENTER_V;
        moving_reg <= 1'b0;
      end else if (active) begin
        moving_reg <= mv;
        if (mv) pos_reg <= pos_next;
      end
    end

    assign bus.pos[gi*POS_W +: POS_W] = pos_reg;
    assign bus.moving[gi]             = moving_reg;
  end
endmodule

// File: tb/tb_gun_pos_accum.sv
// Scoreboard bench for gun_pos_accum: a behavioural model predicts each pass, the monitor
// compares positions, moving flags and done timing whenever done pulses.
module tb_gun_pos_accum;
  localparam int CHANNELS    = 2;
  localparam int POS_W       = 8;
  localparam int POS_MIN     = 0;
  localparam int POS_MAX     = 255;
  localparam int POS_CENTER  = 128;
  localparam int STEP_MAX    = 4;
  localparam int ACCEL_TICKS = 8;
  localparam int PW          = CHANNELS * POS_W;
  localparam logic [PW-1:0] CTR_VEC = {CHANNELS{POS_W'(POS_CENTER)}};
`ifdef GUN_ACCEL_EN
  localparam int EXP_FIRST  = 129;
  localparam int EXP_HOLD17 = 155;
`else
  localparam int EXP_FIRST  = 132;
  localparam int EXP_HOLD17 = 196;
`endif

  typedef struct {
    logic [PW-1:0]       pos;
    logic [CHANNELS-1:0] moving;
    int                  cyc;
  } exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pass_no = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   m_pos[CHANNELS];
  int   m_run[CHANNELS];
  logic m_up[CHANNELS];
  logic [PW-1:0]       m_pos_vec;
  logic [CHANNELS-1:0] m_mov_vec;

  gun_pos_accum_if #(.CHANNELS(CHANNELS), .POS_W(POS_W)) bus ();

  gun_pos_accum #(
    .CHANNELS(CHANNELS), .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_CENTER(POS_CENTER), .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int c = 0; c < CHANNELS; c++) begin
      m_pos[c] = POS_CENTER;
      m_run[c] = 0;
      m_up[c]  = 1'b0;
    end
  endtask

  // Speed follows from the length of the current same-direction run.
  task automatic model_pass(input logic [CHANNELS-1:0] inc, input logic [CHANNELS-1:0] dec,
                            input logic wrap);
    int spd;
    int s;
    for (int c = 0; c < CHANNELS; c++) begin
      m_mov_vec[c] = inc[c] ^ dec[c];
      if (inc[c] ^ dec[c]) begin
        if (m_run[c] > 0 && m_up[c] == inc[c]) m_run[c]++;
        else m_run[c] = 1;
        m_up[c] = inc[c];
`ifdef GUN_ACCEL_EN
        spd = 1 + (m_run[c] - 1) / ACCEL_TICKS;
        if (spd > STEP_MAX) spd = STEP_MAX;
`else
        spd = STEP_MAX;
`endif
        s = inc[c] ? m_pos[c] + spd : m_pos[c] - spd;
        if (s > POS_MAX)      s = wrap ? POS_MIN + (s - POS_MAX - 1) : POS_MAX;
        else if (s < POS_MIN) s = wrap ? POS_MAX - (POS_MIN - s - 1) : POS_MIN;
        m_pos[c] = s;
      end else begin
        m_run[c] = 0;
      end
      m_pos_vec[c*POS_W +: POS_W] = POS_W'(m_pos[c]);
    end
  endtask

  task automatic push_exp(input int at);
    exp_t e;
    e.pos    = m_pos_vec;
    e.moving = m_mov_vec;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Called just after a falling edge; the tick is sampled on the next rising edge.
  task automatic drive_pass(input logic [CHANNELS-1:0] inc, input logic [CHANNELS-1:0] dec,
                            input logic wrap);
    bus.dir_inc   = inc;
    bus.dir_dec   = dec;
    bus.wrap_mode = wrap;
    bus.tick      = 1'b1;
    model_pass(inc, dec, wrap);
    push_exp(cyc + CHANNELS + 1);
    @(negedge clk_sys);
    bus.tick = 1'b0;
    wait_drain();
  endtask

  task automatic do_center(input logic with_tick);
    bus.center = 1'b1;
    bus.tick   = with_tick;
    @(negedge clk_sys);
    bus.center = 1'b0;
    bus.tick   = 1'b0;
    model_init();
  endtask

  always @(negedge clk_sys) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        pass_no++;
        $display("pass %0d cyc=%0d pos=%h moving=%b", pass_no, cyc, bus.pos, bus.moving);
        check_eq("pos", 32'(bus.pos), 32'(mon_e.pos));
        check_eq("moving", 32'(bus.moving), 32'(mon_e.moving));
        check_eq("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0 finish, expected 1");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bus.tick      = 1'b0;
    bus.dir_inc   = '0;
    bus.dir_dec   = '0;
    bus.wrap_mode = 1'b0;
    bus.center    = 1'b0;
    model_init();

    repeat (3) @(negedge clk_sys);
    check_eq("rst_pos", 32'(bus.pos), 32'(CTR_VEC));
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    check_eq("rst_moving", 32'(bus.moving), 32'd0);

    // Tick together with reset release: must be taken on the first edge.
    @(negedge clk_sys);
    reset_n = 1'b1;
    drive_pass(2'b01, 2'b00, 1'b0);
    check_eq("first_pos0", 32'(bus.pos[POS_W-1:0]), 32'(EXP_FIRST));
    check_eq("first_pos1", 32'(bus.pos[2*POS_W-1:POS_W]), 32'(POS_CENTER));
    check_eq("overrun_clear", 32'(bus.overrun), 32'd0);

    do_center(1'b0);
    for (int i = 0; i < 17; i++) drive_pass(2'b01, 2'b00, 1'b0);
    check_eq("hold17_pos0", 32'(bus.pos[POS_W-1:0]), 32'(EXP_HOLD17));

    for (int i = 0; i < 20; i++)
      drive_pass(CHANNELS'($urandom), CHANNELS'($urandom), 1'($urandom));

    // Drive both axes into the range ends, then step past them in wrap mode.
    do_center(1'b0);
    for (int i = 0; i < 40; i++) drive_pass(2'b01, 2'b10, 1'b0);
    check_eq("clamp_hi", 32'(bus.pos[POS_W-1:0]), 32'd255);
    check_eq("clamp_lo", 32'(bus.pos[2*POS_W-1:POS_W]), 32'd0);
    drive_pass(2'b01, 2'b10, 1'b1);
    check_eq("wrap_hi", 32'(bus.pos[POS_W-1:0]), 32'd3);
    check_eq("wrap_lo", 32'(bus.pos[2*POS_W-1:POS_W]), 32'd252);

    // Ticks in three consecutive cycles: two passes, third tick lost.
    do_center(1'b0);
    bus.dir_inc   = 2'b01;
    bus.dir_dec   = 2'b00;
    bus.wrap_mode = 1'b0;
    bus.tick      = 1'b1;
    model_pass(2'b01, 2'b00, 1'b0);
    push_exp(cyc + 3);
    model_pass(2'b01, 2'b00, 1'b0);
    push_exp(cyc + 6);
    repeat (3) @(negedge clk_sys);
    bus.tick = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk_sys);
    check_eq("overrun_set", 32'(bus.overrun), 32'd1);

    // Recenter one cycle after a tick aborts the pass.
    bus.dir_inc = 2'b11;
    bus.dir_dec = 2'b00;
    bus.tick    = 1'b1;
    @(negedge clk_sys);
    do_center(1'b0);
    repeat (6) @(negedge clk_sys);
    check_eq("center_pos", 32'(bus.pos), 32'(CTR_VEC));
    check_eq("center_moving", 32'(bus.moving), 32'd0);
    check_eq("center_keeps_overrun", 32'(bus.overrun), 32'd1);
    drive_pass(2'b00, 2'b00, 1'b0);
    drive_pass(2'b10, 2'b00, 1'b0);
    do_center(1'b1);
    repeat (6) @(negedge clk_sys);
    check_eq("center_tick_pos", 32'(bus.pos), 32'(CTR_VEC));

    // Asynchronous reset in the middle of a pass.
    drive_pass(2'b11, 2'b00, 1'b0);
    bus.tick = 1'b1;
    @(negedge clk_sys);
    bus.tick = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_eq("midrst_pos", 32'(bus.pos), 32'(CTR_VEC));
    check_eq("midrst_overrun", 32'(bus.overrun), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_moving", 32'(bus.moving), 32'd0);
    model_init();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    drive_pass(2'b10, 2'b01, 1'b1);
    repeat (4) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gun_pos_accum.md
GUN_POS_ACCUM -- requirements
Module: gun_pos_accum

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2: number of independent position axes.
REQ-002 SHALL provide parameter POS_W, default 8: position width in bits.
REQ-003 SHALL provide parameters POS_MIN, POS_MAX and POS_CENTER, defaults 0, 255 and 128: position range and recenter value, with POS_MIN <= POS_CENTER <= POS_MAX.
REQ-004 SHALL provide parameter STEP_MAX, default 4: maximum step per tick, 1 <= STEP_MAX <= POS_MAX-POS_MIN.
REQ-005 SHALL provide parameter ACCEL_TICKS, default 8: consecutive moving ticks per speed increment.
REQ-006 SHALL have the following ports; one clock; reset is asynchronous and active-low:
  - clk_sys  input  1  system clock; all logic is on its rising edge.
  - reset_n  input  1  asynchronous active-low reset.
  - tick  input  1  one-cycle frame strobe that triggers an update pass.
  - dir_inc  input  CHANNELS  per-channel increment request (level).
  - dir_dec  input  CHANNELS  per-channel decrement request (level).
  - wrap_mode  input  1  1 = wrap at range ends, 0 = clamp at range ends.
  - center  input  1  synchronous recenter request (level).
  - pos  output  CHANNELS*POS_W  packed positions; channel 0 in the LSBs.
  - moving  output  CHANNELS  channel moved in the last completed pass.
  - done  output  1  one-cycle pulse when a pass completes.
  - overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-007 SHALL implement an FSM with states IDLE, UPDATE and DONE.
REQ-008 SHALL, on tick in IDLE, snapshot dir_inc, dir_dec and wrap_mode and enter UPDATE on the next edge.
REQ-009 SHALL process one channel per cycle in UPDATE, in order 0..CHANNELS-1, then enter DONE; done SHALL assert for the single DONE cycle, i.e. at cycle T+CHANNELS+1 for a tick at cycle T.
REQ-010 SHALL update pos[ch] and moving[ch] in that channel's UPDATE cycle; each pos output SHALL otherwise hold its value.
REQ-011 SHALL treat a channel as moving when the snapshot inc XOR dec = 1; with both or neither set, the channel SHALL not move, speed SHALL go to 0, tick count SHALL go to 0, and moving[ch] SHALL be 0.
REQ-012 SHALL apply per-channel speed as follows: the first moving tick, or a tick where direction reverses, uses speed 1; speed SHALL increment after every ACCEL_TICKS consecutive same-direction moving ticks, saturating at STEP_MAX.
REQ-013 SHALL compute sum = pos ± speed in POS_W+2 signed bits.
REQ-014 SHALL, in clamp mode, saturate the result to POS_MIN..POS_MAX.
REQ-015 SHALL, in wrap mode, map sum > POS_MAX to POS_MIN+(sum-POS_MAX-1) and sum < POS_MIN to POS_MAX-(POS_MIN-sum-1).
REQ-016 SHALL, on tick while not in IDLE, set a one-deep pending flag; the FSM SHALL re-enter UPDATE from DONE with a fresh snapshot taken in the DONE cycle, skipping IDLE.
REQ-017 SHALL drop a tick arriving while pending is already set and set overrun; only reset SHALL clear overrun.
REQ-018 SHALL give center priority over all other activity in any state: on the next edge all pos = POS_CENTER, speeds and tick counts = 0, moving = 0, pending = 0, FSM = IDLE, and no done pulse; a tick coincident with center SHALL be ignored.

Reset
REQ-019 SHALL, when reset_n = 0, immediately force pos = POS_CENTER on all channels, moving = 0, done = 0, overrun = 0, pending = 0, speeds and counters = 0, and FSM = IDLE, including mid-pass.
REQ-020 SHALL accept a tick on the first edge after reset_n deasserts.

Configuration
REQ-021 SHALL, with GUN_ACCEL_EN defined, implement acceleration per REQ-012.
REQ-022 SHALL, with GUN_ACCEL_EN undefined, omit the acceleration counters and use a fixed speed of STEP_MAX for every moving tick; all other behaviour SHALL be unchanged.

Verification (defaults, GUN_ACCEL_EN defined unless noted)
REQ-023 SHALL cover: reset_n low then high -> pos = {128,128}, done = 0, overrun = 0.
REQ-024 SHALL cover: dir_inc = 01 and one tick at cycle T -> done at T+3, pos0 = 129, pos1 = 128, moving = 01.
REQ-025 SHALL cover: dir_inc[0] held for 17 ticks -> pos0 = 128+8*1+8*2+3 = 155; with GUN_ACCEL_EN undefined -> 128+17*4 = 196.
REQ-026 SHALL cover: pos0 = 254 at speed 4 with inc -> clamp mode gives 255; wrap mode gives 2.
REQ-027 SHALL cover: ticks at T, T+1 and T+2 -> two done pulses at T+3 and T+6, third tick dropped, overrun = 1.
REQ-028 SHALL cover: center asserted in the cycle after a tick -> all pos = 128, no done pulse, FSM back in IDLE.
